// File: rtl/mem_pkg.sv
// +----------------------------------------------------------------------+
// | mem_pkg : shared memory geometry, port id and request types           |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

package mem_pkg;

    localparam int MEM_AW = 10;
    localparam int MEM_DW = 32;

    typedef logic port_id_t;

    typedef struct packed {
        logic              we;
        logic [MEM_AW-1:0] addr;
        logic [MEM_DW-1:0] wdata;
    } mem_req_t;

endpackage

`default_nettype wire

// File: rtl/memory.sv
// +----------------------------------------------------------------------+
// | memory : single-port synchronous RAM, read-first, registered dout     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module memory #(
    parameter int AW = 10,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    logic [DW-1:0] mem_q [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= din;
        end
        dout <= mem_q[addr];
    end

endmodule

`default_nettype wire

// File: rtl/rr_arb2.sv
// +----------------------------------------------------------------------+
// | rr_arb2 : two-way round-robin grant with last_grant history           |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module rr_arb2
    import mem_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid_i,
    input  logic       accept_i,
    output port_id_t   grant_o
);

    port_id_t last_grant_q;
    port_id_t last_grant_d;

    always_comb begin
        grant_o = ~last_grant_q;
        case (valid_i)
            2'b01:   grant_o = 1'b0;
            2'b10:   grant_o = 1'b1;
            default: grant_o = ~last_grant_q;
        endcase
    end

    assign last_grant_d = accept_i ? grant_o : last_grant_q;

    // Reset to 1 so port 0 wins the first contention.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// +----------------------------------------------------------------------+
// | mem_arbiter : 2-port round-robin front end for single-port memory     |
// | Option: define ARB_WR_ACK_EN to acknowledge writes on rspN_valid_o    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module mem_arbiter
    import mem_pkg::*;
#(
    parameter int AW = MEM_AW,
    parameter int DW = MEM_DW,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid_i,
    output logic          req0_ready_o,
    input  logic          req0_we_i,
    input  logic [AW-1:0] req0_addr_i,
    input  logic [DW-1:0] req0_wdata_i,
    input  logic          req1_valid_i,
    output logic          req1_ready_o,
    input  logic          req1_we_i,
    input  logic [AW-1:0] req1_addr_i,
    input  logic [DW-1:0] req1_wdata_i,
    output logic          rsp0_valid_o,
    output logic [DW-1:0] rsp0_rdata_o,
    output logic          rsp1_valid_o,
    output logic [DW-1:0] rsp1_rdata_o,
    output logic [CW-1:0] cnt0_o,
    output logic [CW-1:0] cnt1_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_din_o,
    input  logic [DW-1:0] mem_dout_i
);

    logic [1:0]    valid;
    logic [1:0]    ready;
    logic          accept;
    port_id_t      grant;
    mem_req_t      req [2];
    mem_req_t      sel;
    logic [CW-1:0] cnt_q [2];
    logic [CW-1:0] cnt_d [2];
    logic          rsp_act;
    port_id_t      rsp_port;
    logic          rsp_zero;

    assign valid = {req1_valid_i, req0_valid_i};

    always_comb begin
        req[0] = '{we: req0_we_i, addr: req0_addr_i, wdata: req0_wdata_i};
        req[1] = '{we: req1_we_i, addr: req1_addr_i, wdata: req1_wdata_i};
    end

    rr_arb2 u_rr_arb2 (
        .clk      (clk),
        .rst      (rst),
        .valid_i  (valid),
        .accept_i (accept),
        .grant_o  (grant)
    );

    assign ready[0]     = ~rst & valid[0] & (grant == 1'b0);
    assign ready[1]     = ~rst & valid[1] & (grant == 1'b1);
    assign accept       = |ready;
    assign req0_ready_o = ready[0];
    assign req1_ready_o = ready[1];
    assign sel          = req[grant];

    // Idle cycles park the port on a harmless read of address 0.
    always_comb begin
        mem_we_o   = 1'b0;
        mem_addr_o = '0;
        mem_din_o  = '0;
        if (accept) begin
            mem_we_o   = sel.we;
            mem_addr_o = sel.addr;
            mem_din_o  = sel.wdata;
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = cnt_q[i];
            if (ready[i] && (cnt_q[i] != {CW{1'b1}})) begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                cnt_q[i] <= '0;
            end else begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign cnt0_o = cnt_q[0];
    assign cnt1_o = cnt_q[1];

`ifdef ARB_WR_ACK_EN
    logic     pend_q;
    logic     pend_d;
    logic     pend_we_q;
    logic     pend_we_d;
    port_id_t pend_port_q;
    port_id_t pend_port_d;

    assign pend_d      = accept;
    assign pend_we_d   = sel.we;
    assign pend_port_d = grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q      <= 1'b0;
            pend_we_q   <= 1'b0;
            pend_port_q <= 1'b0;
        end else begin
            pend_q      <= pend_d;
            pend_we_q   <= pend_we_d;
            pend_port_q <= pend_port_d;
        end
    end

    assign rsp_act  = pend_q;
    assign rsp_port = pend_port_q;
    assign rsp_zero = pend_we_q;
`else
    logic     rd_pend_q;
    logic     rd_pend_d;
    port_id_t rd_port_q;
    port_id_t rd_port_d;

    assign rd_pend_d = accept & ~sel.we;
    assign rd_port_d = grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend_q <= 1'b0;
            rd_port_q <= 1'b0;
        end else begin
            rd_pend_q <= rd_pend_d;
            rd_port_q <= rd_port_d;
        end
    end

    assign rsp_act  = rd_pend_q;
    assign rsp_port = rd_port_q;
    assign rsp_zero = 1'b0;
`endif

    // Gating with rst drops a response that was in flight when reset hit.
    assign rsp0_valid_o = ~rst & rsp_act & (rsp_port == 1'b0);
    assign rsp1_valid_o = ~rst & rsp_act & (rsp_port == 1'b1);
    assign rsp0_rdata_o = (rsp0_valid_o & ~rsp_zero) ? mem_dout_i : '0;
    assign rsp1_rdata_o = (rsp1_valid_o & ~rsp_zero) ? mem_dout_i : '0;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// +----------------------------------------------------------------------+
// | tb_mem_arbiter : directed scoreboard bench for mem_arbiter + memory   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_mem_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          v0 = 1'b0, we0 = 1'b0, v1 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] a0 = '0, a1 = '0;
    logic [DW-1:0] d0 = '0, d1 = '0;
    logic          r0, r1, rv0, rv1, mem_we;
    logic [DW-1:0] rd0, rd1, mem_din, mem_dout;
    logic [AW-1:0] mem_addr;
    logic [CW-1:0] cnt0, cnt1;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(AW), .DW(DW), .CW(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .req0_valid_i (v0),
        .req0_ready_o (r0),
        .req0_we_i    (we0),
        .req0_addr_i  (a0),
        .req0_wdata_i (d0),
        .req1_valid_i (v1),
        .req1_ready_o (r1),
        .req1_we_i    (we1),
        .req1_addr_i  (a1),
        .req1_wdata_i (d1),
        .rsp0_valid_o (rv0),
        .rsp0_rdata_o (rd0),
        .rsp1_valid_o (rv1),
        .rsp1_rdata_o (rd1),
        .cnt0_o       (cnt0),
        .cnt1_o       (cnt1),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_din_o    (mem_din),
        .mem_dout_i   (mem_dout)
    );

    memory #(.AW(AW), .DW(DW)) u_mem (
        .clk  (clk),
        .we   (mem_we),
        .addr (mem_addr),
        .din  (mem_din),
        .dout (mem_dout)
    );

    typedef struct packed {
        logic          port;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sb [$];
    logic [DW-1:0] ref_mem [int];
    logic          m_last;
    int            m_cnt [2];
    logic [7:0]    glog;
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Predict the grant, check the memory port, update the model and push any response.
    task automatic pre();
        logic          g;
        logic          acc;
        logic          we;
        logic [AW-1:0] ad;
        logic [DW-1:0] wd;
        #1;
        acc = v0 | v1;
        if (v0 && !v1)      g = 1'b0;
        else if (v1 && !v0) g = 1'b1;
        else                g = ~m_last;
        we = g ? we1 : we0;
        ad = g ? a1 : a0;
        wd = g ? d1 : d0;
        chk("ready0", r0, acc && (g == 1'b0));
        chk("ready1", r1, acc && (g == 1'b1));
        chk("mem_we", mem_we, acc && we);
        if (acc) begin
            chk("mem_addr", mem_addr, ad);
            if (we) chk("mem_din", mem_din, wd);
            m_last = g;
            glog   = {glog[6:0], g};
            if (m_cnt[g] < (1 << CW) - 1) m_cnt[g]++;
            if (!we) begin
                sb.push_back('{port: g, data: ref_mem[int'(ad)]});
            end else begin
                ref_mem[int'(ad)] = wd;
`ifdef ARB_WR_ACK_EN
                sb.push_back('{port: g, data: '0});
`endif
            end
        end
    endtask

    task automatic post();
        exp_t e;
        @(posedge clk);
        @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.port ? "rsp1_valid" : "rsp0_valid", e.port ? rv1 : rv0, 1);
            chk("rsp_other_valid", e.port ? rv0 : rv1, 0);
            chk("rsp_rdata", e.port ? rd1 : rd0, e.data);
        end else begin
            chk("rsp0_idle", rv0, 0);
            chk("rsp1_idle", rv1, 0);
            chk("rdata_idle", rd0 | rd1, 0);
        end
        chk("cnt0", cnt0, m_cnt[0]);
        chk("cnt1", cnt1, m_cnt[1]);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        v0  = 1'b0;
        v1  = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #1;
        rst      = 1'b0;
        m_last   = 1'b1;
        m_cnt[0] = 0;
        m_cnt[1] = 0;
        sb.delete();
    endtask

    initial begin
        m_last = 1'b1;
        m_cnt  = '{0, 0};
        glog   = '0;

        // Reset state with both requesters pushing writes.
        v0 = 1'b1; we0 = 1'b1; a0 = 10'h001; d0 = 32'h1;
        v1 = 1'b1; we1 = 1'b1; a1 = 10'h002; d1 = 32'h2;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_ready0", r0, 0);
        chk("rst_ready1", r1, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_rsp0", rv0, 0);
        chk("rst_rsp1", rv1, 0);
        do_reset();
        chk("rst_cnt0", cnt0, 0);
        chk("rst_cnt1", cnt1, 0);

        // Single-port write then read-back.
        v0 = 1'b1; we0 = 1'b1; a0 = 10'h005; d0 = 32'hDEADBEEF;
        pre(); post();
        we0 = 1'b0;
        pre(); post();
        v0 = 1'b0;
        chk("wr_rd_cnt0", cnt0, 2);

        // Preload contention addresses from port 1.
        v1 = 1'b1; we1 = 1'b1; a1 = 10'h010; d1 = 32'hA5A5_0010;
        pre(); post();
        a1 = 10'h020; d1 = 32'h5A5A_0020;
        pre(); post();
        v1 = 1'b0;

        // Contention right after reset: port 0 first.
        do_reset();
        v0 = 1'b1; we0 = 1'b0; a0 = 10'h010;
        v1 = 1'b1; we1 = 1'b0; a1 = 10'h020;
        pre();
        chk("first_grant_p0", r0, 1);
        post();
        v0 = 1'b0;
        pre(); post();
        v1 = 1'b0;
        pre(); post();

        // Sustained contention alternates 0,1,0,1...
        do_reset();
        glog = '0;
        v0 = 1'b1; we0 = 1'b1; a0 = 10'h100; d0 = 32'h0000_0100;
        v1 = 1'b1; we1 = 1'b1; a1 = 10'h180; d1 = 32'h0000_0180;
        for (int i = 0; i < 8; i++) begin
            pre(); post();
        end
        v0 = 1'b0; v1 = 1'b0;
        chk("alternation", glog, 8'h55);
        chk("sust_cnt0", cnt0, 4);
        chk("sust_cnt1", cnt1, 4);

        // Reset arrives while a port-1 read is in flight.
        do_reset();
        v1 = 1'b1; we1 = 1'b0; a1 = 10'h010;
        pre();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        v1  = 1'b0;
        v0  = 1'b1; we0 = 1'b1; a0 = 10'h3FF; d0 = 32'hFFFF_FFFF;
        #1;
        chk("midrst_rsp1", rv1, 0);
        chk("midrst_mem_we", mem_we, 0);
        chk("midrst_ready0", r0, 0);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("midrst_cnt1", cnt1, 0);
        chk("midrst_rsp1_after", rv1, 0);
        do_reset();

        // Port-1 write: acknowledged only when the option is built in.
        v1 = 1'b1; we1 = 1'b1; a1 = 10'h030; d1 = 32'h1234_5678;
        pre(); post();
        v1 = 1'b0;

        // Counter saturation at 2^CW-1.
        do_reset();
        v0 = 1'b1; we0 = 1'b0; a0 = 10'h005;
        for (int i = 0; i < 20; i++) begin
            pre(); post();
        end
        v0 = 1'b0;
        chk("sat_cnt0", cnt0, 15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
